// File: rtl/mc_move_checker.sv
// Receive-side checker for the missionary/cannibal solver: validates each bank state as a legal crossing.
// Optional revisit detection is enabled by defining MC_CHECKER_LOOP_DETECT_EN.
module mc_move_checker #(
   parameter int N_PEOPLE  = 3,
   parameter int CNT_W     = 2,
   parameter int BOAT_CAP  = 2,
   parameter int MAX_MOVES = 15,
   parameter int MOVE_W    = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   input  logic [CNT_W-1:0]  in_missionary_i,
   input  logic [CNT_W-1:0]  in_cannibal_i,
   output logic              move_ok_o,
   output logic              error_o,
   output logic [2:0]        error_code_o,
   output logic              finish_o,
   output logic              boat_side_o,
   output logic [MOVE_W-1:0] move_count_o
);

   // state  | meaning
   // S_IDLE | waiting for the start state N/N
   // S_RUN  | checking each crossing
   // S_DONE | goal 0/0 reached legally, terminal
   // S_FAIL | violation latched, terminal
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

   localparam int              SW    = CNT_W + 1;
   localparam logic [CNT_W-1:0] NP   = CNT_W'(N_PEOPLE);
   localparam logic [SW:0]     CAP_V = (SW+1)'(BOAT_CAP);
   localparam logic [MOVE_W-1:0] MAX_V = MOVE_W'(MAX_MOVES);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    prev_m_q, prev_m_d, prev_c_q, prev_c_d;
   logic                boat_q, boat_d;
   logic [MOVE_W-1:0]   cnt_q, cnt_d;
   logic                move_ok_q, move_ok_d;
   logic                err_q, err_d;
   logic [2:0]          code_q, code_d;
   logic                fin_q, fin_d;

   logic signed [SW-1:0] dm, dc;
   logic [SW-1:0]        dm_abs, dc_abs;
   logic [SW:0]          load;
   logic [CNT_W-1:0]     far_m, far_c;
   logic                 range_err, dir_err, cap_err, unsafe_err, limit_err, revisit_err;
   logic                 is_start, is_goal;
   logic [2:0]           step_code;

`ifdef MC_CHECKER_LOOP_DETECT_EN
   localparam int NP1   = N_PEOPLE + 1;
   localparam int VIS_N = 2 * NP1 * NP1;
   localparam int IW    = $clog2(VIS_N);
   logic [VIS_N-1:0] visited_q, visited_d;
   logic [IW-1:0]    idx_new, idx_start;
   assign idx_new   = IW'(int'(~boat_q) * NP1 * NP1 + int'(in_missionary_i) * NP1
                          + int'(in_cannibal_i));
   assign idx_start = IW'(N_PEOPLE * NP1 + N_PEOPLE);
   assign revisit_err = !range_err && visited_q[idx_new];
`else
   assign revisit_err = 1'b0;
`endif

   always_comb begin
      dm = $signed({1'b0, prev_m_q}) - $signed({1'b0, in_missionary_i});
      dc = $signed({1'b0, prev_c_q}) - $signed({1'b0, in_cannibal_i});
      dm_abs = dm[SW-1] ? SW'(-dm) : SW'(dm);
      dc_abs = dc[SW-1] ? SW'(-dc) : SW'(dc);
      load   = {1'b0, dm_abs} + {1'b0, dc_abs};
      far_m  = NP - in_missionary_i;
      far_c  = NP - in_cannibal_i;
   end

   assign range_err  = (in_missionary_i > NP) || (in_cannibal_i > NP);
   // Boat on start bank: people may only leave it; on far bank: only return.
   assign dir_err    = boat_q ? ((!dm[SW-1] && dm != '0) || (!dc[SW-1] && dc != '0))
                              : (dm[SW-1] || dc[SW-1]);
   assign cap_err    = (load == '0) || (load > CAP_V);
   assign unsafe_err = ((in_missionary_i != '0) && (in_missionary_i < in_cannibal_i))
                    || ((far_m != '0) && (far_m < far_c));
   assign limit_err  = (cnt_q == MAX_V);
   assign is_start   = (in_missionary_i == NP) && (in_cannibal_i == NP);
   assign is_goal    = (in_missionary_i == '0) && (in_cannibal_i == '0);

   always_comb begin
      step_code = 3'd0;
      if (range_err)        step_code = 3'd2;
      else if (dir_err)     step_code = 3'd4;
      else if (cap_err)     step_code = 3'd3;
      else if (unsafe_err)  step_code = 3'd5;
      else if (limit_err)   step_code = 3'd6;
      else if (revisit_err) step_code = 3'd7;
   end

   always_comb begin
      state_d   = state_q;
      prev_m_d  = prev_m_q;
      prev_c_d  = prev_c_q;
      boat_d    = boat_q;
      cnt_d     = cnt_q;
      move_ok_d = 1'b0;
      err_d     = err_q;
      code_d    = code_q;
      fin_d     = fin_q;
`ifdef MC_CHECKER_LOOP_DETECT_EN
      visited_d = visited_q;
`endif
      case (state_q)
         S_IDLE: if (in_valid_i) begin
            if (is_start) begin
               state_d = S_RUN;
`ifdef MC_CHECKER_LOOP_DETECT_EN
               visited_d[idx_start] = 1'b1;
`endif
            end else begin
               state_d = S_FAIL;
               err_d   = 1'b1;
               code_d  = 3'd1;
            end
         end
         S_RUN: if (in_valid_i) begin
            if (step_code != 3'd0) begin
               state_d = S_FAIL;
               err_d   = 1'b1;
               code_d  = step_code;
            end else begin
               prev_m_d  = in_missionary_i;
               prev_c_d  = in_cannibal_i;
               boat_d    = ~boat_q;
               cnt_d     = cnt_q + 1'b1;
               move_ok_d = 1'b1;
`ifdef MC_CHECKER_LOOP_DETECT_EN
               visited_d[idx_new] = 1'b1;
`endif
               if (is_goal) begin
                  fin_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         prev_m_q  <= NP;
         prev_c_q  <= NP;
         boat_q    <= 1'b0;
         cnt_q     <= '0;
         move_ok_q <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= 3'd0;
         fin_q     <= 1'b0;
`ifdef MC_CHECKER_LOOP_DETECT_EN
         visited_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         prev_m_q  <= prev_m_d;
         prev_c_q  <= prev_c_d;
         boat_q    <= boat_d;
         cnt_q     <= cnt_d;
         move_ok_q <= move_ok_d;
         err_q     <= err_d;
         code_q    <= code_d;
         fin_q     <= fin_d;
`ifdef MC_CHECKER_LOOP_DETECT_EN
         visited_q <= visited_d;
`endif
      end
   end

   assign move_ok_o    = move_ok_q;
   assign error_o      = err_q;
   assign error_code_o = code_q;
   assign finish_o     = fin_q;
   assign boat_side_o  = boat_q;
   assign move_count_o = cnt_q;

endmodule

// File: tb/tb_mc_move_checker.sv
// Directed bench for mc_move_checker: legal solution, each error code reachable with 2-bit counts,
// terminal-state input ignoring and mid-run asynchronous reset.
module tb_mc_move_checker;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_m = 2'd0;
   logic [1:0] in_c = 2'd0;
   logic       move_ok, error, finish, boat_side;
   logic [2:0] error_code;
   logic [3:0] move_count;

   int total = 0;
   int bad   = 0;

   int full_m [12] = '{3, 3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
   int full_c [12] = '{3, 1, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};

   mc_move_checker dut (
      .clock_i         (clock),
      .reset_i         (reset),
      .in_valid_i      (in_valid),
      .in_missionary_i (in_m),
      .in_cannibal_i   (in_c),
      .move_ok_o       (move_ok),
      .error_o         (error),
      .error_code_o    (error_code),
      .finish_o        (finish),
      .boat_side_o     (boat_side),
      .move_count_o    (move_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic ok, input logic err, input logic [2:0] code,
                        input logic fin, input logic side, input logic [3:0] cnt);
      logic [10:0] obs, exp;
      obs = {move_ok, error, error_code, finish, boat_side, move_count};
      exp = {ok, err, code, fin, side, cnt};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got ok=%b err=%b code=%0d fin=%b side=%b cnt=%0d, expected ok=%b err=%b code=%0d fin=%b side=%b cnt=%0d",
                tag, move_ok, error, error_code, finish, boat_side, move_count,
                ok, err, code, fin, side, cnt);
      end
   endtask

   task automatic step(input int m, input int c);
      in_valid = 1'b1;
      in_m     = 2'(m);
      in_c     = 2'(c);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic full_run(input string tag);
      step(full_m[0], full_c[0]);
      check({tag, "_start"}, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
      for (int k = 1; k < 12; k++) begin
         step(full_m[k], full_c[k]);
         check($sformatf("%s_step%0d", tag, k), 1'b1, 1'b0, 3'd0, (k == 11), 1'(k % 2), 4'(k));
      end
   endtask

   initial begin
      @(negedge clock);
      do_reset();
      check("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

      full_run("full");
      @(negedge clock);
      check("full_idle", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 4'd11);
      step(3, 1);
      check("done_ignores", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 4'd11);

      do_reset();
      check("reset2", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
      step(2, 2);
      check("bad_start", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd0);
      step(3, 3);
      step(3, 1);
      check("fail_ignores", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd0);

      do_reset();
      step(3, 3);
      step(1, 3);
      check("unsafe", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 4'd0);

      do_reset();
      step(3, 3);
      step(3, 1);
      check("dir_pre", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'd1);
      step(3, 0);
      check("direction", 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 4'd1);

      do_reset();
      step(3, 3);
      step(3, 3);
      check("empty_boat", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'd0);

      do_reset();
      step(3, 3);
      step(3, 0);
      check("overload", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'd0);

      do_reset();
      step(3, 3);
`ifndef MC_CHECKER_LOOP_DETECT_EN
      for (int i = 1; i <= 15; i++) begin
         step(3, (i % 2 == 1) ? 1 : 3);
         check($sformatf("shuttle%0d", i), 1'b1, 1'b0, 3'd0, 1'b0, 1'(i % 2), 4'(i));
      end
      step(3, 3);
      check("limit", 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 4'd15);
`else
      step(3, 1);
      check("shuttle1", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'd1);
      step(3, 3);
      check("revisit", 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 4'd1);
`endif

      do_reset();
      for (int k = 0; k < 6; k++) step(full_m[k], full_c[k]);
      check("mid_run", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'd5);
      #2 reset = 1'b1;
      @(negedge clock);
      check("async_reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
      reset = 1'b0;
      full_run("rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
